// File: rtl/dsp_stage_router.sv
// Valid/ready chain of external DSP stages with a per-stage bypass mask. A new mask is
// applied only after the samples already in the chain have left through dout.
module dsp_stage_router #(
    parameter int G_NUM_STAGES    = 4,
    parameter int G_DWIDTH        = 24,
    parameter int G_INFLIGHT_W    = 8,
    parameter int G_DRAIN_TIMEOUT = 4096
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             enable,
    input  logic [G_NUM_STAGES-1:0]          bypass_req,
    output logic [G_NUM_STAGES-1:0]          bypass_active,
    output logic                             reconfig_busy,
    output logic                             drain_timeout,
    input  logic [G_DWIDTH-1:0]              din,
    input  logic                             din_valid,
    output logic                             din_ready,
    output logic [G_DWIDTH-1:0]              dout,
    output logic                             dout_valid,
    input  logic                             dout_ready,
    output logic [G_NUM_STAGES*G_DWIDTH-1:0] stg_din,
    output logic [G_NUM_STAGES-1:0]          stg_din_valid,
    input  logic [G_NUM_STAGES-1:0]          stg_din_ready,
    input  logic [G_NUM_STAGES*G_DWIDTH-1:0] stg_dout,
    input  logic [G_NUM_STAGES-1:0]          stg_dout_valid,
    output logic [G_NUM_STAGES-1:0]          stg_dout_ready
);

    localparam int CNT_W = $clog2(G_DRAIN_TIMEOUT);
    localparam logic [G_INFLIGHT_W-1:0] INFLIGHT_MAX = '1;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(G_DRAIN_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    state_t                  state_r, state_nxt_s;
    logic [G_NUM_STAGES-1:0] bypass_active_r, active_nxt_s;
    logic [G_NUM_STAGES-1:0] target_r, target_nxt_s;
    logic [G_INFLIGHT_W-1:0] inflight_r, inflight_nxt_s;
    logic [CNT_W-1:0]        drain_cnt_r, drain_cnt_nxt_s;
    logic                    drain_timeout_r, drain_timeout_nxt_s;

    logic                    in_open_s;
    logic                    flush_s;
    logic [G_DWIDTH-1:0]     fwd_data_s;
    logic                    fwd_valid_s;
    logic                    bwd_ready_s;
    logic                    din_hs_s;
    logic                    dout_hs_s;

    // New samples enter only in RUN, out of reset, enabled, with counter headroom;
    // flush mode drops everything the stages present and offers nothing downstream.
    assign in_open_s = resetn & enable & (state_r == ST_RUN) & (inflight_r != INFLIGHT_MAX);
    assign flush_s   = ~resetn | ~enable | (state_r == ST_SWITCH);

    // Forward path: each active stage takes the output of the nearest active stage below it.
    always_comb begin
        fwd_data_s    = din;
        fwd_valid_s   = din_valid & in_open_s;
        stg_din       = '0;
        stg_din_valid = '0;
        for (int k = 0; k < G_NUM_STAGES; k++) begin
            stg_din[k*G_DWIDTH +: G_DWIDTH] = fwd_data_s;
            if (!bypass_active_r[k]) begin
                stg_din_valid[k] = fwd_valid_s & ~flush_s;
                fwd_data_s       = stg_dout[k*G_DWIDTH +: G_DWIDTH];
                fwd_valid_s      = stg_dout_valid[k];
            end else begin
                stg_din_valid[k] = 1'b0;
            end
        end
        dout       = fwd_data_s;
        dout_valid = fwd_valid_s & ~flush_s;
    end

    // Backward path: a source's ready is its sink's ready; bypassed outputs are always drained.
    always_comb begin
        bwd_ready_s    = dout_ready;
        stg_dout_ready = '1;
        for (int k = G_NUM_STAGES - 1; k >= 0; k--) begin
            if (!bypass_active_r[k]) begin
                stg_dout_ready[k] = bwd_ready_s | flush_s;
                bwd_ready_s       = stg_din_ready[k];
            end else begin
                stg_dout_ready[k] = 1'b1;
            end
        end
        din_ready = bwd_ready_s & in_open_s;
    end

    assign din_hs_s  = din_valid & din_ready;
    assign dout_hs_s = dout_valid & dout_ready;

    // Reconfiguration FSM and in-flight accounting.
    always_comb begin
        state_nxt_s         = state_r;
        target_nxt_s        = target_r;
        active_nxt_s        = bypass_active_r;
        drain_cnt_nxt_s     = drain_cnt_r;
        drain_timeout_nxt_s = drain_timeout_r;
        inflight_nxt_s      = inflight_r;
        // The decrement guard keeps stragglers after a forced switch from wrapping the count.
        if (din_hs_s && !dout_hs_s) begin
            inflight_nxt_s = inflight_r + G_INFLIGHT_W'(1);
        end else if (!din_hs_s && dout_hs_s && (inflight_r != '0)) begin
            inflight_nxt_s = inflight_r - G_INFLIGHT_W'(1);
        end else begin
            inflight_nxt_s = inflight_r;
        end
        case (state_r)
            ST_RUN: begin
                if (bypass_req != bypass_active_r) begin
                    target_nxt_s    = bypass_req;
                    drain_cnt_nxt_s = '0;
                    state_nxt_s     = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (inflight_r == '0) begin
                    state_nxt_s = ST_SWITCH;
                end else if (drain_cnt_r == DRAIN_LAST) begin
                    drain_timeout_nxt_s = 1'b1;
                    inflight_nxt_s      = '0;
                    state_nxt_s         = ST_SWITCH;
                end else begin
                    drain_cnt_nxt_s = drain_cnt_r + CNT_W'(1);
                end
            end
            ST_SWITCH: begin
                active_nxt_s = target_r;
                state_nxt_s  = ST_RUN;
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // State registers; enable=0 re-routes immediately without draining.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r         <= ST_RUN;
            bypass_active_r <= '1;
            target_r        <= '1;
            inflight_r      <= '0;
            drain_cnt_r     <= '0;
            drain_timeout_r <= 1'b0;
        end else if (!enable) begin
            state_r         <= ST_RUN;
            bypass_active_r <= bypass_req;
            target_r        <= bypass_req;
            inflight_r      <= '0;
            drain_cnt_r     <= '0;
            drain_timeout_r <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            bypass_active_r <= active_nxt_s;
            target_r        <= target_nxt_s;
            inflight_r      <= inflight_nxt_s;
            drain_cnt_r     <= drain_cnt_nxt_s;
            drain_timeout_r <= drain_timeout_nxt_s;
        end
    end

    assign bypass_active = bypass_active_r;
    assign reconfig_busy = (state_r != ST_RUN);
    assign drain_timeout = drain_timeout_r;

endmodule

// File: tb/tb_dsp_stage_router.sv
// Bench for dsp_stage_router: four 2-deep identity FIFO stages, a ramp driver that queues
// each issued sample, and a monitor that matches every dout handshake against that queue.
module tb_dsp_stage_router;

    localparam int N  = 4;
    localparam int DW = 24;
    localparam int IW = 3;
    localparam int TO = 16;

    logic            clk, resetn, enable;
    logic [N-1:0]    bypass_req, bypass_active;
    logic            reconfig_busy, drain_timeout;
    logic [DW-1:0]   din, dout;
    logic            din_valid, din_ready, dout_valid, dout_ready;
    logic [N*DW-1:0] stg_din, stg_dout;
    logic [N-1:0]    stg_din_valid, stg_din_ready, stg_dout_valid, stg_dout_ready;
    logic [N-1:0]    s_push, s_pop;

    logic [DW-1:0]   mem0 [N];
    logic [DW-1:0]   mem1 [N];
    logic [1:0]      cnt  [N];

    logic [DW-1:0]   exp_q [$];
    int              checks, failures, n_out;
    event            pre_ev;

    dsp_stage_router #(
        .G_NUM_STAGES(N), .G_DWIDTH(DW), .G_INFLIGHT_W(IW), .G_DRAIN_TIMEOUT(TO)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable),
        .bypass_req(bypass_req), .bypass_active(bypass_active),
        .reconfig_busy(reconfig_busy), .drain_timeout(drain_timeout),
        .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .stg_din(stg_din), .stg_din_valid(stg_din_valid), .stg_din_ready(stg_din_ready),
        .stg_dout(stg_dout), .stg_dout_valid(stg_dout_valid), .stg_dout_ready(stg_dout_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Sampling point one time unit before each rising edge.
    always begin
        @(negedge clk);
        #4;
        -> pre_ev;
    end

    assign s_push = stg_din_valid & stg_din_ready;
    assign s_pop  = stg_dout_valid & stg_dout_ready;

    for (genvar g = 0; g < N; g++) begin : g_stage
        assign stg_din_ready[g]         = (cnt[g] < 2'd2);
        assign stg_dout_valid[g]        = (cnt[g] != 2'd0);
        assign stg_dout[g*DW +: DW]     = mem0[g];
    end

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < N; k++) cnt[k] <= 2'd0;
        end else begin
            for (int k = 0; k < N; k++) begin
                case ({s_push[k], s_pop[k]})
                    2'b10: begin
                        if (cnt[k] == 2'd0) mem0[k] <= stg_din[k*DW +: DW];
                        else                mem1[k] <= stg_din[k*DW +: DW];
                        cnt[k] <= cnt[k] + 2'd1;
                    end
                    2'b01: begin
                        mem0[k] <= mem1[k];
                        cnt[k]  <= cnt[k] - 2'd1;
                    end
                    2'b11: begin
                        if (cnt[k] == 2'd1) begin
                            mem0[k] <= stg_din[k*DW +: DW];
                        end else begin
                            mem0[k] <= mem1[k];
                            mem1[k] <= stg_din[k*DW +: DW];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted dout must be the oldest issued sample.
    always @(pre_ev) begin
        if (resetn === 1'b1 && dout_valid === 1'b1 && dout_ready === 1'b1) begin
            n_out++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dout_unexpected: got %0h expected no sample", dout);
            end else begin
                check("dout_data", 32'(dout), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic send(input logic [DW-1:0] v);
        bit hs = 1'b0;
        exp_q.push_back(v);
        din       = v;
        din_valid = 1'b1;
        for (int i = 0; i < 100 && !hs; i++) begin
            @(pre_ev);
            hs = din_ready;
            @(negedge clk);
        end
        din_valid = 1'b0;
        if (!hs) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: sample %0h got din_ready=0 expected 1", v);
        end
    endtask

    task automatic wait_mask(input logic [N-1:0] m);
        int i = 0;
        while (i < 50 && !(reconfig_busy == 1'b0 && bypass_active == m)) begin
            @(negedge clk);
            #1;
            i++;
        end
        check("mask_settle", 32'({reconfig_busy, bypass_active}), 32'({1'b0, m}));
    endtask

    task automatic wait_empty();
        int i = 0;
        while (i < 200 && exp_q.size() != 0) begin
            @(negedge clk);
            #1;
            i++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected summary before it");
        $fatal(1, "bench time limit");
    end

    initial begin
        int bad, idle_cnt, acc, out0, occ, max_occ, guard;
        bit pend;
        logic [DW-1:0] v;
        checks = 0; failures = 0; n_out = 0;
        resetn = 1'b0; enable = 1'b1; bypass_req = 4'b0000;
        din = 24'h0; din_valid = 1'b0; dout_ready = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        check("rst_outputs",
              32'({reconfig_busy, bypass_active, drain_timeout, din_ready, dout_valid, stg_din_valid}),
              32'({1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000}));
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("post_rst_mask", 32'(bypass_active), 32'(4'b1111));
        wait_mask(4'b0000);

        // Full chain, 200-sample ramp.
        for (int i = 0; i < 200; i++) send(DW'(i));
        wait_empty();

        // Hitless bypass of stage 1 with three samples held in the chain.
        dout_ready = 1'b0;
        for (int i = 200; i < 203; i++) send(DW'(i));
        bypass_req = 4'b0010;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (!(reconfig_busy && !din_ready)) bad++;
        end
        check("drain_hold", 32'(bad), 32'd0);
        dout_ready = 1'b1;
        idle_cnt = 0;
        guard = 0;
        do begin
            @(negedge clk);
            #1;
            guard++;
            if (reconfig_busy) begin
                if (din_ready) bad++;
                if (exp_q.size() == 0) idle_cnt++;
            end
        end while (reconfig_busy && guard < 40);
        check("drain_no_input", 32'(bad), 32'd0);
        check("empty_busy_cycles", 32'(idle_cnt), 32'd2);
        check("mask_0010", 32'(bypass_active), 32'(4'b0010));
        for (int i = 203; i < 223; i++) send(DW'(i));
        wait_empty();

        // Empty pipe, best-case timing to all-bypassed.
        @(negedge clk);
        bypass_req = 4'b1111;
        #1;
        check("t0_run", 32'(reconfig_busy), 32'd0);
        @(negedge clk);
        #1;
        check("t1_drain", 32'({reconfig_busy, bypass_active}), 32'({1'b1, 4'b0010}));
        @(negedge clk);
        din = 24'h5A5A5A;
        din_valid = 1'b1;
        #1;
        check("t2_switch", 32'({reconfig_busy, din_ready, dout_valid, stg_din_valid}),
              32'({1'b1, 1'b0, 1'b0, 4'b0000}));
        @(negedge clk);
        din_valid = 1'b0;
        #1;
        check("t3_mask", 32'({reconfig_busy, bypass_active}), 32'({1'b0, 4'b1111}));
        exp_q.push_back(24'hABCDEF);
        din = 24'hABCDEF;
        din_valid = 1'b1;
        #1;
        check("comb_pass", 32'({dout_valid, din_ready, dout}), 32'({1'b1, 1'b1, 24'hABCDEF}));
        @(negedge clk);
        din_valid = 1'b0;

        // Forced switch after TO drain cycles with dout stalled.
        bypass_req = 4'b0000;
        wait_mask(4'b0000);
        dout_ready = 1'b0;
        send(24'h000300);
        send(24'h000301);
        repeat (3) @(negedge clk);
        bypass_req = 4'b0001;
        repeat (16) @(negedge clk);
        #1;
        check("to_last_drain", 32'({reconfig_busy, drain_timeout}), 32'(2'b10));
        @(negedge clk);
        #1;
        check("to_switch", 32'({reconfig_busy, drain_timeout}), 32'(2'b11));
        @(negedge clk);
        #1;
        check("to_run", 32'({reconfig_busy, drain_timeout, bypass_active}),
              32'({1'b0, 1'b1, 4'b0001}));
        repeat (5) @(negedge clk);
        #1;
        check("to_sticky", 32'(drain_timeout), 32'd1);
        @(negedge clk);
        enable = 1'b0;
        bypass_req = 4'b0000;
        dout_ready = 1'b1;
        exp_q.delete();
        #1;
        check("dis_gated", 32'({din_ready, dout_valid, stg_din_valid}), 32'd0);
        @(negedge clk);
        #1;
        check("dis_clear", 32'({reconfig_busy, drain_timeout, bypass_active}), 32'd0);
        repeat (5) @(negedge clk);
        enable = 1'b1;

        // In-flight limit of 2^IW-1 with dout stalled, then sustained flow.
        @(negedge clk);
        dout_ready = 1'b0;
        acc = 0;
        pend = 1'b0;
        v = 24'd400;
        out0 = n_out;
        repeat (20) begin
            if (!pend) begin
                exp_q.push_back(v);
                din = v;
                din_valid = 1'b1;
                pend = 1'b1;
            end
            @(pre_ev);
            if (din_ready) begin
                acc++;
                pend = 1'b0;
                v = v + 24'd1;
            end
            @(negedge clk);
        end
        check("accept_limit", 32'(acc), 32'd7);
        #1;
        check("full_din_ready", 32'(din_ready), 32'd0);
        dout_ready = 1'b1;
        max_occ = acc - (n_out - out0);
        guard = 0;
        while (acc < 37 && guard < 300) begin
            if (!pend) begin
                exp_q.push_back(v);
                din = v;
                din_valid = 1'b1;
                pend = 1'b1;
            end
            @(pre_ev);
            if (din_ready) begin
                acc++;
                pend = 1'b0;
                v = v + 24'd1;
            end
            @(negedge clk);
            occ = acc - (n_out - out0);
            if (occ > max_occ) max_occ = occ;
            guard++;
        end
        din_valid = 1'b0;
        check("stream_accepts", 32'(acc), 32'd37);
        check("occupancy_max", 32'(max_occ), 32'd7);
        wait_empty();

        // Reset asserted in the middle of a drain.
        @(negedge clk);
        dout_ready = 1'b0;
        send(24'h000500);
        send(24'h000501);
        bypass_req = 4'b0100;
        repeat (3) @(negedge clk);
        #1;
        check("rst_pre_drain", 32'(reconfig_busy), 32'd1);
        #1;
        resetn = 1'b0;
        exp_q.delete();
        bypass_req = 4'b1111;
        #1;
        check("rst_async",
              32'({reconfig_busy, bypass_active, drain_timeout, din_ready, dout_valid, stg_din_valid}),
              32'({1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000}));
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("rst_release", 32'({reconfig_busy, bypass_active}), 32'({1'b0, 4'b1111}));
        @(negedge clk);
        #1;
        check("rst_first_edge", 32'({reconfig_busy, bypass_active}), 32'({1'b0, 4'b1111}));
        dout_ready = 1'b1;
        send(24'h000600);
        wait_empty();

        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
